rr_mux_arbiter: RTL
===================

Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one W-bit mux datapath among N requesters using a valid/ready handshake on every side.
- Picks one valid requester per cycle and drives the mux select. Latches the selected word into a one-entry registered output stage, tagged with the requester index.
- Sits between several producer blocks and a single shared consumer. It is the sequencing layer on top of the mux primitives in the combinational section.

Parameters:
- N, 4, number of requesters (2..16).
- W, 8, data width per requester.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  N  per-requester valid; bit i belongs to requester i.
- in_ready  output  N  per-requester ready; at most one bit high per cycle.
- in_data  input  N*W  flattened requester data; requester i occupies bits [i*W +: W].
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  W  selected word.
- out_id  output  $clog2(N)  index of the requester that supplied out_data.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid=0, out_data=0, out_id=0.
  - last_grant pointer=N-1, so requester 0 has top priority after reset.
  - in_ready=0 while rst_n is low.
- load_en = !out_valid || out_ready (output stage empty, or draining this cycle).
- Arbitration, combinational: search from (last_grant+1) mod N upward with wrap, and grant the first i with in_valid[i]=1.
  - in_ready[i] = grant[i] && load_en. It must not depend on out_ready when out_valid=0.
- Transfer from requester i happens on an edge where in_valid[i] && in_ready[i]. On that edge:
  - out_data <= in_data[i], out_id <= i, out_valid <= 1, last_grant <= i.
- Output drain happens on an edge where out_valid && out_ready.
  - If no transfer occurs on the same edge, out_valid <= 0. out_data and out_id hold their values.
- Simultaneous drain and transfer on the same edge: the new word replaces the old one and out_valid stays 1. Throughput is 1 word/cycle.
- Latency: a word accepted on edge k is visible on out_* from edge k until drained (1-cycle registered).
- Stall: out_valid=1 && out_ready=0 forces all in_ready low.
  - out_data and out_id stay stable, with no glitching.
  - last_grant does not move.
- last_grant updates only on an actual transfer. A pending request with no transfer does not advance the pointer.
- Fairness: with all N requesters continuously valid and out_ready=1, the grant order is 0,1,...,N-1,0,... Any requester that holds in_valid high is served within N transfers.
- No requester valid: in_ready=0, the output drains normally, and the pointer holds.
- Requester withdrawing valid before acceptance is legal. Arbitration re-evaluates each cycle.
- Reset mid-operation: any held word is discarded (out_valid=0 immediately), pointer returns to N-1. First grant after release goes to the lowest valid index.
- Combinational paths: in_ready depends on out_ready (pipeline-ready path). out_* are driven only from registers.

Decomposition:
- Package rr_mux_arbiter_pkg:
  - default N and W constants.
  - id width localparam via $clog2.
  - a function rotate-and-pick helper usable by the bench model.
- Sub-module rr_priority_picker: combinational.
  - Inputs: req[N], last[$clog2(N)].
  - Outputs: onehot grant[N], grant_idx, any.
- Top module instantiates the picker and holds the output register plus the last_grant pointer.

Test Plan:
- Reset then single requester: in_valid=4'b0100, in_data[2]=8'hA5, out_ready=1 -> in_ready=4'b0100. Next cycle out_valid=1, out_data=A5, out_id=2.
- Round-robin: in_valid=4'b1111, data[i]=8'h10+i, out_ready=1 held 8 cycles -> out_id sequence 0,1,2,3,0,1,2,3 with no bubbles.
- Backpressure: out_valid=1 (id=1, data=11), out_ready=0 for 5 cycles, all in_valid=1 -> in_ready=0, out_data=11, out_id=1 stable. On out_ready=1 the next grant is id=2.
- Skip and wrap: last_grant=2, in_valid=4'b0011 -> grant id=0, then id=1, then id=0. Requesters 2 and 3 never granted while invalid.
- Simultaneous drain and load: out_valid=1, out_ready=1, in_valid=4'b1000 -> out_valid stays 1, out_id=3 next cycle, one word per cycle.
- Async reset mid-stream: pull rst_n low between edges while out_valid=1 -> out_valid=0 immediately. After release with in_valid=4'b1010, first out_id=1.

Source files
------------

// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared constants and round-robin pick helper
package rr_mux_arbiter_pkg;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 8;
    localparam int DEFAULT_ID_W = $clog2(DEFAULT_N);

    // Width of a requester index; a single-bit index is kept even for tiny N.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Rotate-and-pick: search upward from (last+1) mod n with wrap and return
    // {found, index} of the first asserted request. Supports n up to 16.
    function automatic logic [4:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  last,
                                           input int          n);
        logic [4:0] result;
        int         idx;
        result = '0;
        idx    = 0;
        for (int off = 1; off <= 16; off++) begin
            if (off <= n) begin
                idx = (int'(last) + off) % n;
                if (!result[4] && req[idx]) begin
                    result = {1'b1, 4'(idx)};
                end
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational rotating-priority request picker
//
// Ports:
//   req       N-bit request vector
//   last      index granted most recently; its successor has top priority
//   grant     one-hot grant, all zero when nothing requests
//   grant_idx binary index of the granted requester
//   any       at least one request is asserted
module rr_priority_picker
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N    = DEFAULT_N,
    parameter int ID_W = id_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] last,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_idx,
    output logic            any
);

    logic [4:0] pick;

    always_comb begin
        pick      = rr_pick(16'(req), 4'(last), N);
        any       = pick[4];
        grant_idx = ID_W'(pick[3:0]);
        grant     = '0;
        for (int i = 0; i < N; i++) begin
            grant[i] = pick[4] && (int'(pick[3:0]) == i);
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - round-robin arbiter feeding a shared one-entry output stage
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   in_valid    per-requester valid
//   in_ready    per-requester ready, at most one bit high
//   in_data     flattened requester data, requester i at [i*W +: W]
//   out_valid   output register holds a word
//   out_ready   consumer accepts the held word
//   out_data    held word
//   out_id      index of the requester that supplied out_data
module rr_mux_arbiter
    import rr_mux_arbiter_pkg::*;
#(
    parameter int N = DEFAULT_N,
    parameter int W = DEFAULT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic [N*W-1:0]       in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [W-1:0]         out_data,
    output logic [id_width(N)-1:0] out_id
);

    localparam int ID_W = id_width(N);

    logic [ID_W-1:0] last_grant;
    logic [N-1:0]    grant;
    logic [ID_W-1:0] grant_idx;
    logic            any;
    logic            load_en;
    logic            transfer;
    logic [W-1:0]    sel_data;

    rr_priority_picker #(
        .N    (N),
        .ID_W (ID_W)
    ) u_picker (
        .req       (in_valid),
        .last      (last_grant),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (any)
    );

    // The stage can load when empty or when it is being drained this cycle;
    // out_ready only matters while a word is held.
    assign load_en  = !out_valid || out_ready;
    // Gating with rst_n keeps ready low throughout reset even though the
    // picker already sees a valid pointer.
    assign in_ready = (rst_n && load_en) ? grant : '0;
    assign transfer = rst_n && load_en && any;
    assign sel_data = in_data[grant_idx*W +: W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_id     <= '0;
            last_grant <= ID_W'(N - 1);
        end else if (transfer) begin
            out_valid  <= 1'b1;
            out_data   <= sel_data;
            out_id     <= grant_idx;
            last_grant <= grant_idx;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

endmodule
